// File: rtl/dm_bus_responder.sv
// dm_bus_responder: debug module bus device responder backed by a word register file
// Ports: clk_i/rst_ni clock and asynchronous active-low reset; req/we/addr/be/wdata host
//        request held until gnt; gnt combinational grant; r_valid/rdata/r_err/r_other_err
//        registered response one cycle after the grant.
// Optional: define DM_BUS_RESP_WPROT_EN to write-protect the lower half of the region.
module dm_bus_responder #(
   parameter int unsigned          BusWidth   = 32,
   parameter logic [BusWidth-1:0]  BaseAddr   = BusWidth'(32'h0000_0800),
   parameter int unsigned          Depth      = 16,
   parameter int unsigned          WaitStates = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req,
   input  logic                  we,
   input  logic [BusWidth-1:0]   addr,
   input  logic [BusWidth/8-1:0] be,
   input  logic [BusWidth-1:0]   wdata,
   output logic                  gnt,
   output logic                  r_valid,
   output logic [BusWidth-1:0]   rdata,
   output logic                  r_err,
   output logic                  r_other_err
);
   localparam int unsigned NB = BusWidth / 8;
   localparam int unsigned AW = $clog2(NB);
   localparam int unsigned IW = $clog2(Depth);
   localparam logic [BusWidth-1:0] SIZE = BusWidth'(Depth * NB);
   localparam logic [2:0] CNT0 = 3'(WaitStates == 0 ? 0 : WaitStates - 1);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state;
   logic [2:0] cnt;
   logic [BusWidth-1:0] mem [Depth];
   logic [BusWidth-1:0] off;
   logic [IW-1:0] idx;
   logic mis, inr, prot, wr_ok;
   assign off = addr - BaseAddr;
   assign idx = off[AW +: IW];
   assign mis = addr[AW-1:0] != '0;
   // addr >= BaseAddr guards against off wrapping for addresses below the region
   assign inr = addr >= BaseAddr && off < SIZE;
`ifdef DM_BUS_RESP_WPROT_EN
   // lower half of the word array holds the ROM image
   assign prot = we && !idx[IW-1];
`else
   assign prot = 1'b0;
`endif
   // RESP accepts a new request exactly like IDLE, giving one transfer per cycle at WaitStates=0
   assign gnt = rst_ni && req && (state == WAIT ? cnt == 3'd0 : WaitStates == 0);
   assign wr_ok = gnt && we && !mis && inr && !prot;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         cnt <= '0;
         r_valid <= 1'b0;
         rdata <= '0;
         r_err <= 1'b0;
         r_other_err <= 1'b0;
         for (int i = 0; i < Depth; i++) mem[IW'(i)] <= '0;
      end else begin
         r_valid <= gnt;
         rdata <= gnt && !we && !mis && inr ? mem[idx] : '0;
         r_other_err <= gnt && mis;
         r_err <= gnt && !mis && (!inr || prot);
         if (wr_ok)
            for (int i = 0; i < NB; i++)
               if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         if (gnt) begin
            state <= RESP;
         end else if (state == WAIT) begin
            // no grant with req high here means cnt is still counting down
            if (!req) state <= IDLE;
            else cnt <= cnt - 3'd1;
         end else if (req) begin
            state <= WAIT;
            cnt <= CNT0;
         end else begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: doc/dm_bus_responder.md
# dm_bus_responder

Device-side responder for the debug module bus. It accepts host requests (`req`/`we`/`addr`/`be`/`wdata`), grants them after a programmable number of wait states, and returns `r_valid`/`rdata`/`r_err`/`r_other_err` one cycle after the grant. It is backed by a small word-addressed register file holding the program buffer and abstract data words. It sits between the debug module's bus host port and the debug memory region, and doubles as the bus model for host-side verification.

## Interface
- `BusWidth`, 32, data/address width; byte enables are BusWidth/8 bits.
- `BaseAddr`, 32'h0000_0800, first byte address of the region; must be word aligned.
- `Depth`, 16, number of BusWidth-wide words (power of two, 2..256).
- `WaitStates`, 0, cycles between first `req` and `gnt` (0..7).
- `clk_i` input 1: single clock; all state on the rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `req` input 1: host request; held until granted.
- `we` input 1: 1 = write, 0 = read.
- `addr` input BusWidth: byte address.
- `be` input BusWidth/8: byte enables for writes.
- `wdata` input BusWidth: write data.
- `gnt` output 1: request accepted this cycle.
- `r_valid` output 1: response valid; one-cycle pulse.
- `rdata` output BusWidth: read data; 0 for writes and errors.
- `r_err` output 1: out-of-range access.
- `r_other_err` output 1: misaligned access; wins over `r_err`.

## Operation
- States:
  - IDLE
  - WAIT: counter `cnt` of 3 bits.
  - RESP
- IDLE, `req`=1:
  - WaitStates=0: `gnt`=1 combinationally in the same cycle; transfer captured; next state RESP.
  - WaitStates>0: `cnt` loads WaitStates-1; next state WAIT.
- WAIT:
  - `cnt`>0: decrement.
  - `cnt`=0 and `req`=1: `gnt`=1; capture; next state RESP.
  - `req` drops in WAIT: return to IDLE; no grant, no response.
- RESP:
  - `r_valid`=1 for exactly one cycle.
  - A new `req` in RESP is handled exactly as in IDLE, so WaitStates=0 sustains one transfer per cycle.
  - Otherwise go to IDLE.
- Decode at grant:
  - `off` = `addr` − `BaseAddr`.
  - Misaligned when `addr[log2(BusWidth/8)-1:0]` ≠ 0.
  - In range when `addr` ≥ `BaseAddr` and `off` < Depth·BusWidth/8.
  - Word index = `off` >> log2(BusWidth/8).
- Error response:
  - Misaligned: `r_other_err`=1 and `r_err`=0, even if also out of range.
  - Out of range and aligned: `r_err`=1.
  - Errored accesses never modify memory; `rdata`=0.
- Write at grant edge: each byte lane i with `be[i]`=1 is updated; other lanes are held. `be`=0 is a legal no-op write with a clean response.
- Read: `rdata` is the word value sampled at the grant edge. A read granted the cycle after a write to the same word returns the new data.
- `addr`, `we`, `be`, `wdata` are sampled only in the grant cycle.

## Timing
- Reset values: `gnt`=0 (forced while `rst_ni`=0), `r_valid`=0, `rdata`=0, `r_err`=0, `r_other_err`=0, state IDLE, `cnt`=0, all memory words 0.
- Grant latency: WaitStates cycles from the first cycle `req` is high.
- Response latency: `r_valid` asserts exactly one cycle after `gnt`. `rdata`/`r_err`/`r_other_err` are registered, are valid only while `r_valid`=1, and are 0 otherwise.
- At most one outstanding transfer.
- Reset asserted mid-transfer:
  - Any pending response is discarded.
  - Outputs go to reset values immediately (asynchronously).
  - A write granted on an edge before reset assertion remains committed until reset clears memory.

## Configuration
- `DM_BUS_RESP_WPROT_EN`: write-protects the lower half of the region (word index < Depth/2, the ROM image).
  - Defined: in-range, aligned writes to the protected half are dropped and respond with `r_err`=1. Reads are unaffected.
  - Undefined: the whole region is writable. No protection logic is synthesized.

## Test plan
- Reset, then WaitStates=0: write 0xDEADBEEF to 0x800 with `be`=4'hF, then read 0x800 → `gnt` is high in the request cycle; the read's `r_valid` arrives one cycle later with `rdata`=0xDEADBEEF and both error flags 0.
- Byte-lane write: `be`=4'b0010, `wdata`=0x0000AA00 to 0x800 after the previous test → read returns 0xDEADAAEF.
- WaitStates=3: `req` held from cycle 0 → `gnt` in cycle 3 and `r_valid` in cycle 4. Separately, `req` dropped in cycle 1 → no `gnt` and no `r_valid`.
- Error priority:
  - Read 0x802 → `r_other_err`=1, `r_err`=0.
  - Read 0x840 (Depth=16) → `r_err`=1.
  - Read 0x7FC → `r_err`=1.
  - Misaligned out-of-range 0x842 → `r_other_err` only.
  - `rdata`=0 in every case.
- Back-to-back at WaitStates=0: `req` held for 4 reads of 0x800..0x80C → 4 consecutive `gnt` cycles and 4 consecutive `r_valid` pulses with in-order data. Asserting `rst_ni` low in the middle → all outputs 0 immediately; a following read returns 0.
- With `DM_BUS_RESP_WPROT_EN`: write 0x12345678 to 0x800 → `r_err`=1 and a read of 0x800 returns 0. Write to 0x820 → succeeds.
